// File: rtl/hsk_uart_rx.sv
// hsk_uart_rx: 16x-oversampled 8N1 UART receiver for the TURFIO housekeeping link.
// Ports: clk, rst (sync, active-high); en_16x (16x baud tick); rx (async serial in);
//        m_axis_tdata/tvalid/tready (one-deep byte output, LSB = first data bit);
//        frame_err, overrun (single-cycle status pulses).
module hsk_uart_rx #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_16x,
    input  logic       rx,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic rx_s;
    logic done;
    logic load;

    // Normalise polarity so that idle/stop always reads as 1 internally.
    assign rx_s = sync_q[SYNC_STAGES-1] ^ ~IDLE_LEVEL;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = ferr_q;
    assign overrun       = ovr_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        ferr_d  = 1'b0;

        if (en_16x) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        tick_d  = 4'd0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in; a high here was a glitch.
                    if (tick_q == 4'd7) begin
                        tick_d = 4'd0;
                        bit_d  = 4'd0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        shreg_d = {rx_s, shreg_q[7:1]};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            state_d = S_STOP;
                            tick_d  = 4'd0;
                        end
                    end
                end
                S_STOP: begin
                    tick_d = tick_q + 4'd1;
                    // Sampling mid stop bit re-arms half a bit early for drift slack.
                    if (tick_q == 4'd15) begin
                        tick_d = 4'd0;
                        if (rx_s) begin
                            done    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // Hold off until the line returns high so a long low reports once.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        load     = done && (!tvalid_q || m_axis_tready);
        tvalid_d = load || (tvalid_q && !m_axis_tready);
        tdata_d  = load ? shreg_q : tdata_q;
        ovr_d    = done && tvalid_q && !m_axis_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= {SYNC_STAGES{IDLE_LEVEL}};
            state_q  <= S_IDLE;
            tick_q   <= 4'd0;
            bit_q    <= 4'd0;
            shreg_q  <= 8'h00;
            tdata_q  <= 8'h00;
            tvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

endmodule

// File: tb/tb_hsk_uart_rx.sv
// tb_hsk_uart_rx: directed, table-driven bench for hsk_uart_rx.
// Ports: none (top-level bench driving clk, rst, en_16x, rx, tready).
module tb_hsk_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_16x = 1'b0;
    logic       rx = 1'b1;
    logic       m_axis_tready = 1'b1;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    hsk_uart_rx #(
        .SYNC_STAGES(2),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_16x       (en_16x),
        .rx           (rx),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // 16x tick every 4 clocks.
    int en_ph = 0;
    always @(posedge clk) begin
        #1;
        en_ph  = (en_ph == 3) ? 0 : en_ph + 1;
        en_16x = (en_ph == 0);
    end

    // Observation on the falling edge, away from the active edge.
    logic [7:0] beats[$];
    int         tv_cyc = 0;
    int         ferr_cyc = 0;
    int         ovr_cyc = 0;
    int         hold_bad = 0;
    logic       held = 1'b0;
    logic [7:0] held_data = 8'h00;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
        if (m_axis_tvalid) tv_cyc++;
        if (frame_err) ferr_cyc++;
        if (overrun) ovr_cyc++;
        if (held && (m_axis_tdata != held_data)) hold_bad++;
        held      = m_axis_tvalid && !m_axis_tready;
        held_data = m_axis_tdata;
    end

    typedef struct {
        logic [7:0] data;
        int         bc;
        logic       stop;
        int         exp_beats;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int bc, input logic stop);
        rx = 1'b0;
        wclk(bc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wclk(bc);
        end
        rx = stop;
        wclk(bc);
        rx = 1'b1;
    endtask

    function automatic int get_beat(input int idx);
        if (idx < beats.size()) return int'(beats[idx]);
        return -1;
    endfunction

    int b0, t0, f0, o0;
    logic [7:0] v7e;

    initial begin
        vecs[0] = '{8'h55, 64, 1'b1, 1, 8'h55, 0};
        vecs[1] = '{8'hA3, 64, 1'b1, 1, 8'hA3, 0};
        vecs[2] = '{8'h00, 64, 1'b1, 1, 8'h00, 0};
        vecs[3] = '{8'hFF, 64, 1'b1, 1, 8'hFF, 0};
        vecs[4] = '{8'h80, 62, 1'b1, 1, 8'h80, 0};
        vecs[5] = '{8'h01, 66, 1'b1, 1, 8'h01, 0};
        vecs[6] = '{8'h5A, 64, 1'b0, 0, 8'h00, 1};
        vecs[7] = '{8'hC3, 64, 1'b1, 1, 8'hC3, 0};

        rst = 1'b1;
        wclk(4);
        check("reset_tvalid", int'(m_axis_tvalid), 0);
        check("reset_tdata", int'(m_axis_tdata), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        wclk(40);

        // Single-frame vectors.
        for (int i = 0; i < 8; i++) begin
            b0 = beats.size();
            f0 = ferr_cyc;
            o0 = ovr_cyc;
            send_frame(vecs[i].data, vecs[i].bc, vecs[i].stop);
            wclk(128);
            check($sformatf("vec%0d_beats", i), beats.size() - b0, vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0)
                check($sformatf("vec%0d_data", i), get_beat(b0), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), ferr_cyc - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_cyc - o0, 0);
        end

        // Two frames back to back.
        b0 = beats.size(); t0 = tv_cyc; f0 = ferr_cyc; o0 = ovr_cyc;
        send_frame(8'h55, 64, 1'b1);
        send_frame(8'hA3, 64, 1'b1);
        wclk(128);
        check("b2b_beats", beats.size() - b0, 2);
        check("b2b_first", get_beat(b0), 8'h55);
        check("b2b_second", get_beat(b0 + 1), 8'hA3);
        check("b2b_tvalid_cycles", tv_cyc - t0, 2);
        check("b2b_ferr", ferr_cyc - f0, 0);
        check("b2b_ovr", ovr_cyc - o0, 0);

        // Short low glitch must be rejected at the start-bit check.
        b0 = beats.size(); t0 = tv_cyc; f0 = ferr_cyc;
        rx = 1'b0;
        wclk(20);
        rx = 1'b1;
        wclk(1280);
        check("glitch_tvalid_cycles", tv_cyc - t0, 0);
        check("glitch_ferr", ferr_cyc - f0, 0);
        send_frame(8'h3C, 64, 1'b1);
        wclk(128);
        check("glitch_next_beats", beats.size() - b0, 1);
        check("glitch_next_data", get_beat(b0), 8'h3C);

        // Bad stop bit followed by a held-low line.
        b0 = beats.size(); f0 = ferr_cyc; o0 = ovr_cyc;
        send_frame(8'hA3, 64, 1'b0);
        rx = 1'b0;
        wclk(160);
        rx = 1'b1;
        wclk(1280);
        check("break_ferr", ferr_cyc - f0, 1);
        check("break_beats", beats.size() - b0, 0);
        send_frame(8'h12, 64, 1'b1);
        wclk(128);
        check("break_next_beats", beats.size() - b0, 1);
        check("break_next_data", get_beat(b0), 8'h12);
        check("break_ovr", ovr_cyc - o0, 0);

        // Output full: second byte is dropped with an overrun.
        b0 = beats.size(); o0 = ovr_cyc;
        m_axis_tready = 1'b0;
        send_frame(8'h01, 64, 1'b1);
        send_frame(8'h02, 64, 1'b1);
        wclk(128);
        check("ovr_tvalid_held", int'(m_axis_tvalid), 1);
        check("ovr_tdata_held", int'(m_axis_tdata), 8'h01);
        check("ovr_pulses", ovr_cyc - o0, 1);
        check("ovr_no_beat", beats.size() - b0, 0);
        m_axis_tready = 1'b1;
        wclk(4);
        check("ovr_drain_beats", beats.size() - b0, 1);
        check("ovr_drain_data", get_beat(b0), 8'h01);
        check("ovr_drain_tvalid", int'(m_axis_tvalid), 0);
        check("ovr_hold_stable", hold_bad, 0);

        // Reset in the middle of data bit 4 of 0x7E.
        b0 = beats.size(); f0 = ferr_cyc;
        v7e = 8'h7E;
        rx = 1'b0;
        wclk(64);
        for (int i = 0; i < 8; i++) begin
            rx = v7e[i];
            if (i == 4) begin
                wclk(32);
                rst = 1'b1;
                wclk(1);
                check("midrst_tvalid", int'(m_axis_tvalid), 0);
                check("midrst_tdata", int'(m_axis_tdata), 0);
                check("midrst_frame_err", int'(frame_err), 0);
                check("midrst_overrun", int'(overrun), 0);
                rst = 1'b0;
                wclk(31);
            end else begin
                wclk(64);
            end
        end
        rx = 1'b1;
        wclk(64);
        rx = 1'b0;
        wclk(640);
        rx = 1'b1;
        wclk(1280);
        check("midrst_tail_beats", beats.size() - b0, 0);
        check("midrst_tail_ferr", ferr_cyc - f0, 1);
        send_frame(8'h81, 64, 1'b1);
        wclk(128);
        check("midrst_next_beats", beats.size() - b0, 1);
        check("midrst_next_data", get_beat(b0), 8'h81);

        // Zero-gap stream with the line running about 1.5% fast.
        b0 = beats.size(); f0 = ferr_cyc; o0 = ovr_cyc;
        for (int k = 0; k < 16; k++) begin
            send_frame(8'(k), 63, 1'b1);
        end
        wclk(128);
        check("stream_beats", beats.size() - b0, 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("stream_data%0d", k), get_beat(b0 + k), k);
        end
        check("stream_ferr", ferr_cyc - f0, 0);
        check("stream_ovr", ovr_cyc - o0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
